// File: rtl/muldiv_pkg.sv
// Shared encodings and types for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam int ITERS = 32;

    typedef logic [4:0] cnt_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t PREP = 3'd1;
    localparam state_t ITER = 3'd2;
    localparam state_t FIX  = 3'd3;
    localparam state_t DONE = 3'd4;

endpackage

// File: rtl/twos_negate_32bit.sv
// 32-bit inverter followed by an increment; carry pins let two instances chain into a 64-bit negate.
module twos_negate_32bit (
    input  logic [31:0] value,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out
);

    assign {carry_out, result} = {1'b0, ~value} + {32'd0, carry_in};

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS MULT/MULTU/DIV/DIVU unit: 32-step shift-add multiply or restoring divide on one shared adder.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = muldiv_pkg::ITERS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    import muldiv_pkg::*;

    state_t      state;
    cnt_t        cnt;
    logic [1:0]  op_q;
    logic        sign_a, sign_b;
    logic [31:0] opa, opb, acc_hi, acc_lo;

    logic        is_div, is_signed;
    logic [31:0] neg_a, neg_b, mag_a, mag_b;
    logic [31:0] neg_lo, neg_hi;
    logic        lo_cout;
    logic        cout_unused_a, cout_unused_b, cout_unused_hi;
    logic [33:0] add_x, add_y, sum;
    logic        add_cin;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    twos_negate_32bit u_neg_a  (.value(opa),    .carry_in(1'b1), .result(neg_a),  .carry_out(cout_unused_a));
    twos_negate_32bit u_neg_b  (.value(opb),    .carry_in(1'b1), .result(neg_b),  .carry_out(cout_unused_b));
    twos_negate_32bit u_neg_lo (.value(acc_lo), .carry_in(1'b1), .result(neg_lo), .carry_out(lo_cout));
    // Multiply ripples LO's carry into HI; divide negates quotient and remainder independently.
    twos_negate_32bit u_neg_hi (.value(acc_hi), .carry_in(is_div ? 1'b1 : lo_cout),
                                .result(neg_hi), .carry_out(cout_unused_hi));

    assign mag_a = (is_signed && opa[31]) ? neg_a : opa;
    assign mag_b = (is_signed && opb[31]) ? neg_b : opb;

    // 34 bits: divide trials a 33-bit shifted remainder, bit 33 is the borrow.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (is_div) begin
            add_x   = {1'b0, acc_hi, acc_lo[31]};
            add_y   = ~{2'b00, opb};
            add_cin = 1'b1;
        end else begin
            add_x = {2'b00, acc_hi};
            add_y = acc_lo[0] ? {2'b00, opa} : '0;
        end
    end

    assign sum = add_x + add_y + {33'd0, add_cin};

    assign busy = (state == PREP) || (state == ITER) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            opa         <= '0;
            opb         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        opa   <= a;
                        opb   <= b;
                        state <= PREP;
                    end
                end
                PREP: begin
                    sign_a <= is_signed & opa[31];
                    sign_b <= is_signed & opb[31];
                    if (is_div && opb == '0) begin
                        hi          <= opa;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        opa    <= mag_a;
                        opb    <= mag_b;
                        acc_hi <= '0;
                        acc_lo <= is_div ? mag_a : mag_b;
                        cnt    <= '0;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (is_div) begin
                        if (!sum[33]) begin
                            acc_hi <= sum[31:0];
                            acc_lo <= {acc_lo[30:0], 1'b1};
                        end else begin
                            acc_hi <= {acc_hi[30:0], acc_lo[31]};
                            acc_lo <= {acc_lo[30:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= sum[32:1];
                        acc_lo <= {sum[0], acc_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == cnt_t'(ITERS - 1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= (sign_a ^ sign_b) ? neg_lo : acc_lo;
                        hi <= sign_a ? neg_hi : acc_hi;
                    end else if (sign_a ^ sign_b) begin
                        lo <= neg_lo;
                        hi <= neg_hi;
                    end else begin
                        lo <= acc_lo;
                        hi <= acc_hi;
                    end
                    state <= DONE;
                end
                DONE: begin
                    div_by_zero <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
